// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Front-end sequencer. Holds the program counter, reads a synchronous
//   instruction memory (1-cycle read latency) and hands each word to the decode
//   stage under a valid/ready handshake. Branch redirects are taken on accept.
//   The program ends when a HALT_WORD or the word at LAST_ADDR is accepted
//   without a branch.
//
//   Fetch cadence: REQ (address out) -> WAIT (data returns) -> VALID (held).
//   The cadence gives one instruction per 3 cycles at best.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          pulse; starts fetching at START_ADDR (IDLE/DONE only)
//   imem_addr      instruction memory read address (always equals pc)
//   imem_rdata     instruction memory data, one cycle after imem_addr
//   instr          instruction word to the decoder, stable while instr_valid
//   instr_valid    instr holds a fetched word
//   instr_ready    decoder accepts instr this cycle
//   branch_taken   accepted instruction redirects the PC (sampled on accept)
//   branch_target  absolute redirect address (sampled on accept)
//   pc             address of the word in instr / being fetched
//   done           program finished; held until start or reset
//   retired_count  (IFU_RETIRE_COUNT_EN only) saturating count of accepts
//                  since the last honoured start
//
// Optional feature macro: IFU_RETIRE_COUNT_EN
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int unsigned     PC_W       = 10,
   parameter int unsigned     IW         = 9,
   parameter logic [PC_W-1:0] START_ADDR = '0,
   parameter logic [PC_W-1:0] LAST_ADDR  = '1,
   parameter logic [IW-1:0]   HALT_WORD  = '1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   input  logic [IW-1:0]   imem_rdata,
   output logic [IW-1:0]   instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   output logic [PC_W-1:0] pc,
   output logic            done
`ifdef IFU_RETIRE_COUNT_EN
   ,
   output logic [31:0]     retired_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_VALID,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic [IW-1:0]   instr_q;
   logic            valid_q;
   logic            done_q;

   logic            accept;
   logic [PC_W-1:0] pc_inc_d;

   // valid_q is only ever high in VALID, so it doubles as the state qualifier
   assign accept   = valid_q && instr_ready;
   // Natural PC_W-bit wrap: the top address rolls over to 0
   assign pc_inc_d = pc_q + PC_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= START_ADDR;
         instr_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pc_q    <= START_ADDR;
                  state_q <= S_REQ;
               end
            end
            // imem_addr is pc_q; memory samples it at the end of this cycle
            S_REQ: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               instr_q <= imem_rdata;
               valid_q <= 1'b1;
               state_q <= S_VALID;
            end
            S_VALID: begin
               if (accept) begin
                  valid_q <= 1'b0;
                  // Halt outranks both a branch and the last-address stop
                  if (instr_q == HALT_WORD) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else if (branch_taken) begin
                     pc_q    <= branch_target;
                     state_q <= S_REQ;
                  end else if (pc_q == LAST_ADDR) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     pc_q    <= pc_inc_d;
                     state_q <= S_REQ;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  done_q  <= 1'b0;
                  pc_q    <= START_ADDR;
                  state_q <= S_REQ;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign done        = done_q;

`ifdef IFU_RETIRE_COUNT_EN
   logic [31:0] ret_cnt_q;
   logic        start_ok;

   assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ret_cnt_q <= '0;
      end else if (start_ok) begin
         ret_cnt_q <= '0;
      end else if (accept && (ret_cnt_q != 32'hFFFF_FFFF)) begin
         ret_cnt_q <= ret_cnt_q + 32'd1;
      end
   end

   assign retired_count = ret_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   localparam int unsigned     PC_W    = 10;
   localparam int unsigned     IW      = 9;
   localparam logic [IW-1:0]   HALT    = 9'h1FF;
   localparam logic [PC_W-1:0] M_START = 10'd0;
   localparam logic [PC_W-1:0] M_LAST  = 10'd3;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b0;
   logic            instr_ready = 1'b0;
   logic            branch_taken = 1'b0;
   logic [PC_W-1:0] branch_target = '0;
   logic [PC_W-1:0] imem_addr, pc;
   logic [IW-1:0]   imem_rdata, instr;
   logic            instr_valid, done;

   logic            start_w = 1'b0;
   logic [PC_W-1:0] w_addr, w_pc;
   logic [IW-1:0]   w_rdata, w_instr;
   logic            w_valid, w_done;

`ifdef IFU_RETIRE_COUNT_EN
   logic [31:0]     retired_count, w_retired;
`endif

   logic [IW-1:0]   mem [0:1023];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] wword(input logic [PC_W-1:0] a);
      return a[IW-1:0] ^ 9'h0A5;
   endfunction

   always @(posedge clk) imem_rdata <= mem[imem_addr];
   always @(posedge clk) w_rdata <= wword(w_addr);

   instr_fetch_unit #(.PC_W(PC_W), .IW(IW), .START_ADDR(M_START), .LAST_ADDR(M_LAST),
                      .HALT_WORD(HALT)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .branch_taken(branch_taken),
      .branch_target(branch_target), .pc(pc), .done(done)
`ifdef IFU_RETIRE_COUNT_EN
      , .retired_count(retired_count)
`endif
   );

   instr_fetch_unit #(.PC_W(PC_W), .IW(IW), .START_ADDR(10'd1023), .LAST_ADDR(10'd1),
                      .HALT_WORD(HALT)) u_wrap (
      .clk(clk), .reset_n(reset_n), .start(start_w), .imem_addr(w_addr),
      .imem_rdata(w_rdata), .instr(w_instr), .instr_valid(w_valid),
      .instr_ready(1'b1), .branch_taken(1'b0), .branch_target(10'd0),
      .pc(w_pc), .done(w_done)
`ifdef IFU_RETIRE_COUNT_EN
      , .retired_count(w_retired)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct packed {
      logic [PC_W-1:0] a;
      logic [IW-1:0]   w;
   } item_t;

   item_t           exp_q[$];
   int              cyc = 0;
   bit              m_pend = 1'b0;
   bit              m_done = 1'b0;
   logic [PC_W-1:0] m_pc = M_START;
   int              m_t = 0;
   logic [31:0]     m_ret = '0;

   // A fetch requested at the edge opening cycle c shows up in cycle c+2
   function automatic void m_fetch(input logic [PC_W-1:0] a);
      m_pend = 1'b1;
      m_pc   = a;
      m_t    = cyc + 2;
      exp_q.push_back('{a: a, w: mem[a]});
   endfunction

   function automatic bit mv();
      return m_pend && (cyc >= m_t);
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_pend = 1'b0;
            m_done = 1'b0;
            m_pc   = M_START;
            m_ret  = '0;
         end else begin
            cyc++;
            if (!m_pend) begin
               if (start) begin
                  m_done = 1'b0;
                  m_ret  = '0;
                  m_fetch(M_START);
               end
            end else if ((cyc - 1 >= m_t) && instr_ready) begin
               m_pend = 1'b0;
               if (m_ret != 32'hFFFF_FFFF) m_ret++;
               if (mem[m_pc] == HALT) m_done = 1'b1;
               else if (branch_taken) m_fetch(branch_target);
               else if (m_pc == M_LAST) m_done = 1'b1;
               else m_fetch(m_pc + 10'd1);
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      int rd;
      rd = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            rd = exp_q.size();
         end else begin
            chk("valid", 32'(instr_valid), 32'(mv()));
            chk("done", 32'(done), 32'(m_done));
            chk("pc", 32'(pc), 32'(m_pc));
            chk("imem_addr", 32'(imem_addr), 32'(m_pc));
`ifdef IFU_RETIRE_COUNT_EN
            chk("retired_count", retired_count, m_ret);
`endif
            if (instr_valid) begin
               chk("pending_words", exp_q.size() - rd, 1);
               if (rd < exp_q.size()) begin
                  chk("instr", 32'(instr), 32'(exp_q[rd].w));
                  chk("word_pc", 32'(pc), 32'(exp_q[rd].a));
                  if (instr_ready) rd++;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #1;
      chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pc"}, 32'(pc), 32'(M_START));
      chk({tag, "_imem_addr"}, 32'(imem_addr), 32'(M_START));
      chk({tag, "_instr"}, 32'(instr), 32'd0);
      chk({tag, "_wrap_pc"}, 32'(w_pc), 32'd1023);
`ifdef IFU_RETIRE_COUNT_EN
      chk({tag, "_retired"}, retired_count, 32'd0);
`endif
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic straight(input string tag);
      int k;
      instr_ready  = 1'b1;
      branch_taken = 1'b0;
      pulse_start();
      for (k = 0; k < 40 && !m_done; k++) tick();
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_last_pc"}, 32'(pc), 32'(M_LAST));
`ifdef IFU_RETIRE_COUNT_EN
      chk({tag, "_retired"}, retired_count, 32'd4);
`endif
   endtask

   task automatic directed();
      int bp;
      int k;
      bp = 0;
      pulse_start();
      for (k = 0; k < 300 && !m_done; k++) begin
         instr_ready   = 1'b1;
         branch_taken  = 1'b0;
         branch_target = 10'($urandom_range(0, 1023));
         if (mv()) begin
            if (m_pc == 10'd1 && bp < 5) begin
               instr_ready = 1'b0;
               bp++;
            end else if (m_pc == 10'd2) begin
               branch_taken  = 1'b1;
               branch_target = 10'd40;
            end else if (m_pc == 10'd41) begin
               branch_taken  = 1'b1;
               branch_target = 10'd5;
            end else if (m_pc == 10'd5) begin
               branch_taken  = 1'b1;
               branch_target = 10'd0;
            end
         end else begin
            instr_ready  = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
         end
         tick();
      end
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_pc", 32'(pc), 32'd5);
      for (k = 0; k < 4; k++) tick();
      chk("halt_no_fetch", 32'(instr_valid), 32'd0);
   endtask

   initial begin
      logic [PC_W-1:0] wexp [3];
      logic [PC_W-1:0] wa[$];
      int k;

      for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom_range(0, 510));

      tick();
      tick();
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pc", 32'(pc), 32'(M_START));
      chk("rst_instr", 32'(instr), 32'd0);
      reset_n = 1'b1;
      tick();

      // Wrap instance: 1023 -> 0 -> 1, then done
      wexp[0] = 10'd1023;
      wexp[1] = 10'd0;
      wexp[2] = 10'd1;
      start_w = 1'b1;
      tick();
      start_w = 1'b0;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (w_valid) begin
            wa.push_back(w_pc);
            chk("wrap_instr", 32'(w_instr), 32'(wword(w_pc)));
         end
         if (w_done) break;
      end
      tick();
      chk("wrap_count", wa.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < wa.size()) chk("wrap_order", 32'(wa[i]), 32'(wexp[i]));
      end
      chk("wrap_done", 32'(w_done), 32'd1);
      chk("wrap_done_pc", 32'(w_pc), 32'd1);

      straight("straight");

      mem[5] = HALT;
      directed();

      straight("restart");

      // Reset while the first word is in WAIT
      pulse_start();
      tick();
      do_reset("rst_wait");

      // Randomized programs
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom_range(0, 510));
         for (int h = 0; h < 6; h++) mem[10'($urandom_range(0, 1023))] = HALT;
         pulse_start();
         for (k = 0; k < 500 && !m_done; k++) begin
            instr_ready   = ($urandom_range(0, 3) != 0);
            branch_taken  = ($urandom_range(0, 4) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? M_LAST : 10'($urandom_range(0, 1023));
            start         = ($urandom_range(0, 19) == 0);
            tick();
         end
         start = 1'b0;
         if (!m_done) do_reset("rst_rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end sequencer that produces instruction words for the control decoder and datapath.
- Holds the program counter and reads instruction memory (synchronous, 1-cycle read latency).
- Presents each instruction word to the decode stage under a valid/ready handshake.
- Applies branch redirects returned by the execute side, and signals done on a halt word or the last address.

Parameters:
- PC_W, 10, program counter / instruction memory address width
- IW, 9, instruction word width
- START_ADDR, 0, PC loaded on start
- LAST_ADDR, 1023, address whose accepted, non-branching instruction ends the program
- HALT_WORD, 9'h1FF, instruction encoding that ends the program when accepted

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin fetching at START_ADDR (honoured in IDLE/DONE only)
- imem_addr  out  PC_W  instruction memory read address
- imem_rdata  in  IW  instruction memory data, valid the cycle after imem_addr is presented
- instr  out  IW  instruction word to decoder; stable while instr_valid=1
- instr_valid  out  1  instr holds a fetched word
- instr_ready  in  1  decode/execute accepts instr this cycle
- branch_taken  in  1  accepted instruction redirects the PC; sampled only on accept
- branch_target  in  PC_W  absolute redirect address; sampled only on accept
- pc  out  PC_W  address of the word currently in instr / being fetched
- done  out  1  program finished; held until start or reset

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=START_ADDR, imem_addr=START_ADDR, instr=0.
  - instr_valid=0, done=0.
- FSM states: IDLE, REQ, WAIT, VALID, DONE.
- IDLE: start=1 -> pc=START_ADDR, go to REQ. Otherwise stay.
- REQ: imem_addr=pc. Go to WAIT next cycle.
- WAIT: register instr=imem_rdata, set instr_valid=1, go to VALID.
- VALID: hold instr and instr_valid until instr_ready=1. An accept is the cycle with instr_valid && instr_ready. On accept:
  - If instr==HALT_WORD -> DONE (branch inputs ignored).
  - Else if branch_taken -> pc=branch_target, go to REQ.
  - Else if pc==LAST_ADDR -> DONE.
  - Else pc=pc+1 (modulo 2^PC_W; 2^PC_W-1 wraps to 0), go to REQ.
  - instr_valid drops to 0 the cycle after accept.
- DONE: done=1, instr_valid=0, pc frozen. start=1 -> done=0, pc=START_ADDR, go to REQ.
- Latency: start in cycle 0 -> instr_valid=1 in cycle 3. Accept in cycle N -> next instr_valid=1 in cycle N+3. Peak throughput is 1 instruction per 3 cycles.
- imem_addr always equals pc (registered, glitch-free).
- start while in REQ/WAIT/VALID is ignored.
- A branch to LAST_ADDR is allowed; the done check applies when that word is later accepted.
- HALT_WORD takes priority over branch_taken and over LAST_ADDR.
- instr_ready outside VALID has no effect.
- Reset asserted mid-operation aborts immediately; all outputs return to reset values with no partial state retained.

Optional Feature:
- Macro: IFU_RETIRE_COUNT_EN
- Defined:
  - Adds output retired_count (32 bits) = number of accepts since the last start, including the halting word.
  - Clears on reset and on an honoured start.
  - Saturates at 32'hFFFFFFFF.
  - Holds its value in DONE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Straight-line, no halt: program with no halt word, LAST_ADDR=3, instr_ready tied 1, start at cycle 0 -> instr_valid first high in cycle 3. Words at addresses 0,1,2,3 delivered in order 3 cycles apart. done=1 the cycle after accept of address 3.
- Backpressure: instr_ready=0 for 5 cycles while instr_valid=1 at pc=1 -> instr and pc stable throughout. Exactly one accept when ready rises; next word (addr 2) valid 3 cycles later.
- Branch: accept at pc=2 with branch_taken=1, branch_target=10'd40 -> imem_addr=40 in the next cycle. Next word is mem[40]. The branch inputs are ignored in all cycles without an accept.
- Halt priority: mem[5]=HALT_WORD; accept at pc=5 with branch_taken=1, target=0 -> DONE, done=1, no further fetches. start pulse -> done=0, refetch from START_ADDR.
- Wrap: START_ADDR=1023, LAST_ADDR=1, no halt -> fetch order 1023, 0, 1, then done=1.
- Reset mid-fetch: assert reset_n=0 while in WAIT -> instr_valid=0, pc=START_ADDR and done=0 immediately (asynchronous). With IFU_RETIRE_COUNT_EN: retired_count=0 after reset, and equals 4 after the straight-line test.
